aes_cbc_unchain: RTL and testbench
==================================

Name: aes_cbc_unchain

Overview:
- Sits directly downstream of the unrolled AES-128 decrypt pipeline and also drives that pipeline's ciphertext input.
- Accepts ciphertext blocks with a ready/valid handshake and forwards each block to the decryptor. It tracks the decryptor's fixed latency with a valid/mask delay line.
- When each plaintext block emerges, it XORs the block with the previous ciphertext (CBC) or with zero (ECB).
- Finished plaintext is buffered in a FIFO and serialised as 32-bit words with ready/valid backpressure.

Parameters:
- LAT, 3, decryptor latency in cycles from ciphertext input to plaintext output.
- DEPTH, 4, FIFO capacity in 128-bit blocks (≥ LAT+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- iv_load  in  1  load iv_in into the chaining register
- iv_in  in  128  initialisation vector
- cbc_en  in  1  1 = CBC, 0 = ECB; sampled per accepted block
- ct_valid  in  1  ciphertext block valid
- ct_in  in  128  ciphertext block
- ct_ready  out  1  block can be accepted
- dec_in  out  128  ciphertext to the decryptor input
- dec_out  in  128  raw plaintext from the decryptor
- pt_valid  out  1  output word valid
- pt_data  out  32  output word
- pt_last  out  1  last (4th) word of a block
- pt_ready  in  1  downstream accepts the word

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values:
  - ct_ready=0 during rst, 1 on the first cycle after.
  - pt_valid=0, pt_data=0, pt_last=0.
  - Chaining register=0; delay line, FIFO and word counter cleared.
  - Reset mid-operation discards in-flight and buffered blocks. No partial words are emitted afterwards.
- Accept: a block is accepted when ct_valid && ct_ready. dec_in = ct_in combinationally every cycle; the decryptor runs freely.
- Mask selection at acceptance: mask = cbc_en ? chain : 0. If iv_load is high in the same cycle, chain is replaced by iv_in for that mask (iv_load has priority).
- Chaining register update:
  - iv_load alone: chain <= iv_in.
  - Accepted block with cbc_en=1: chain <= ct_in.
  - Both in the same cycle: chain <= ct_in.
  - ECB blocks do not update chain.
- Delay line: LAT stages of {valid, mask[127:0]}. A block accepted in cycle t has its plaintext on dec_out in cycle t+LAT. In that cycle, stage LAT's valid causes dec_out ^ mask to be written into the FIFO.
- Credit flow control:
  - ct_ready = (fifo_count + inflight) < DEPTH, where inflight = number of valid delay stages.
  - The FIFO therefore never overflows.
  - A FIFO write and a FIFO pop-of-last-word in the same cycle are both honoured.
- Serialiser:
  - 2-bit word counter over the FIFO head.
  - pt_data = head[127-32*w -: 32], so word 0 = bits[127:96].
  - pt_last = (w==3).
  - On pt_valid && pt_ready: w increments. After w==3 the head is popped and w returns to 0.
  - pt_data is held stable while pt_valid && !pt_ready.
- Throughput: one block per cycle on input; one word per cycle on output (sustained 1 block / 4 cycles).
- Key: key loading to the decryptor is outside this block. The system must settle the key before the first accept.

Decomposition:
- Shared package aes_pkg: AES_BLK_W=128, AES_WORD_W=32, AES_DEC_LAT=3, block/word typedefs.
- One sub-module: aes_blk_fifo, a synchronous FIFO of 128-bit entries with count output and simultaneous push/pop.

Test Plan:
- CBC, SP800-38A F.2.2:
  - Setup: iv_load IV=000102030405060708090a0b0c0d0e0f; decryptor key 2b7e151628aed2a6abf7158809cf4f3c.
  - Stimulus: blocks 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2.
  - Required: words 6bc1bee2, 2e409f96, e93d7e11, 7393172a, then ae2d8a57, 1e03ac9c, 9eb76fac, 45af8e51, with pt_last on the 4th and 8th words.
- ECB, same key:
  - Stimulus: cbc_en=0, ct 3ad77bb40d7a3660a89ecaf32466ef97.
  - Required: words 6bc1bee2 2e409f96 e93d7e11 7393172a; chain unchanged.
- Backpressure:
  - Stimulus: hold pt_ready=0 and stream ct_valid=1.
  - Required: exactly DEPTH blocks accepted, then ct_ready=0. After pt_ready=1, all 4·DEPTH words arrive in order with no loss or duplication.
- Stall stability: toggle pt_ready pseudo-randomly. Required: pt_data/pt_last stable whenever pt_valid && !pt_ready.
- Simultaneous iv_load + accept:
  - Stimulus: block 1 of the CBC vector with iv_load in the same cycle.
  - Required: block 1 uses the new IV, and block 2 chains from block 1's ciphertext.
- Reset mid-stream:
  - Stimulus: assert rst while 2 blocks are in flight and word 1 is pending.
  - Required: pt_valid=0 the cycle after, nothing from the old blocks is emitted, and chain=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block/word widths, decryptor latency,
// block/word typedefs and a helper that picks a 32-bit word out of a block.
package aes_pkg;

  localparam int unsigned AES_BLK_W   = 128;
  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_DEC_LAT = 3;

  typedef logic [AES_BLK_W-1:0]  aes_blk_t;
  typedef logic [AES_WORD_W-1:0] aes_word_t;

  // Word 0 is the most significant word (bits 127:96).
  function automatic aes_word_t blk_word(aes_blk_t blk, logic [1:0] idx);
    aes_word_t w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous FIFO of 128-bit blocks with occupancy count.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i         write push_data_i (caller guarantees not full)
//   pop_i          drop the head entry (caller guarantees not empty)
//   head_o         current head entry
//   count_o        number of stored entries
// A push and a pop in the same cycle are both honoured.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [AES_BLK_W-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [AES_BLK_W-1:0] head_o,
  output logic [CntW-1:0]      count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  aes_blk_t            mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count_q says so.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/aes_cbc_unchain.sv
// CBC/ECB unchaining stage behind a fixed-latency AES-128 decrypt pipeline.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   iv_load, iv_in             load the chaining register
//   cbc_en                     1 = CBC, 0 = ECB, sampled per accepted block
//   ct_valid, ct_in, ct_ready  ciphertext block handshake
//   dec_in                     ciphertext towards the decryptor (= ct_in)
//   dec_out                    raw plaintext from the decryptor, LAT cycles later
//   pt_valid, pt_data,
//   pt_last, pt_ready          32-bit plaintext word stream, pt_last on word 3
// Each accepted block carries its XOR mask down a LAT-deep delay line so the
// mask meets the matching decryptor output. Input acceptance is credit based:
// a block is only taken if the FIFO has room for it and everything in flight.
module aes_cbc_unchain
  import aes_pkg::*;
#(
  parameter int unsigned LAT   = AES_DEC_LAT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iv_load,
  input  logic [AES_BLK_W-1:0]  iv_in,
  input  logic                  cbc_en,
  input  logic                  ct_valid,
  input  logic [AES_BLK_W-1:0]  ct_in,
  output logic                  ct_ready,
  output logic [AES_BLK_W-1:0]  dec_in,
  input  logic [AES_BLK_W-1:0]  dec_out,
  output logic                  pt_valid,
  output logic [AES_WORD_W-1:0] pt_data,
  output logic                  pt_last,
  input  logic                  pt_ready
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  aes_blk_t        chain_q, chain_d;
  logic [LAT-1:0]  dly_vld_q, dly_vld_d;
  aes_blk_t        dly_mask_q [LAT];
  aes_blk_t        dly_mask_d [LAT];
  logic [1:0]      word_q, word_d;

  logic            accept;
  aes_blk_t        mask;
  int unsigned     credits_used;
  logic            fifo_push, fifo_pop, pt_fire;
  aes_blk_t        fifo_wdata, fifo_head;
  logic [CntW-1:0] fifo_count;

  assign dec_in = ct_in;

  always_comb begin
    credits_used = 32'(fifo_count) + 32'($countones(dly_vld_q));
    ct_ready     = !rst && (credits_used < DEPTH);
    accept       = ct_valid && ct_ready;

    // A same-cycle iv_load wins over the stored chain for this block's mask.
    mask = '0;
    if (cbc_en) begin
      mask = iv_load ? iv_in : chain_q;
    end

    chain_d = chain_q;
    if (accept && cbc_en) begin
      chain_d = ct_in;
    end else if (iv_load) begin
      chain_d = iv_in;
    end

    dly_vld_d[0]  = accept;
    dly_mask_d[0] = mask;
    for (int i = 1; i < LAT; i++) begin
      dly_vld_d[i]  = dly_vld_q[i-1];
      dly_mask_d[i] = dly_mask_q[i-1];
    end

    fifo_push  = dly_vld_q[LAT-1];
    fifo_wdata = dec_out ^ dly_mask_q[LAT-1];

    pt_valid = (fifo_count != '0);
    pt_fire  = pt_valid && pt_ready;
    fifo_pop = pt_fire && (word_q == 2'd3);
    word_d   = pt_fire ? word_q + 2'd1 : word_q;
    pt_last  = pt_valid && (word_q == 2'd3);
    pt_data  = pt_valid ? blk_word(fifo_head, word_q) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q   <= '0;
      dly_vld_q <= '0;
      word_q    <= '0;
    end else begin
      chain_q   <= chain_d;
      dly_vld_q <= dly_vld_d;
      word_q    <= word_d;
    end
  end

  // Masks are qualified by dly_vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    dly_mask_q <= dly_mask_d;
  end

  aes_blk_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (fifo_push),
    .push_data_i(fifo_wdata),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_aes_cbc_unchain.sv
// Bench for aes_cbc_unchain. The AES decryptor is stood in for by a LAT-deep
// pipeline around dec_model(): the SP800-38A ciphertexts map to their true
// raw decryptions, any other block to an arbitrary bijective scramble.
module tb_aes_cbc_unchain;
  import aes_pkg::*;

  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 4;

  localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1    = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CT2    = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CT_ECB = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  // Raw AES-128 decryptions under key 2b7e1516..., before any CBC XOR.
  localparam logic [127:0] RAW1   = PT1 ^ IV;
  localparam logic [127:0] RAW2   = PT2 ^ CT1;

  logic         clk = 1'b0;
  logic         rst, iv_load, cbc_en, ct_valid, ct_ready, pt_valid, pt_last, pt_ready;
  logic [127:0] iv_in, ct_in, dec_in, dec_out;
  logic [31:0]  pt_data;

  always #5 clk = ~clk;

  aes_cbc_unchain #(
    .LAT  (LAT),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .iv_load (iv_load),
    .iv_in   (iv_in),
    .cbc_en  (cbc_en),
    .ct_valid(ct_valid),
    .ct_in   (ct_in),
    .ct_ready(ct_ready),
    .dec_in  (dec_in),
    .dec_out (dec_out),
    .pt_valid(pt_valid),
    .pt_data (pt_data),
    .pt_last (pt_last),
    .pt_ready(pt_ready)
  );

  function automatic logic [127:0] dec_model(input logic [127:0] c);
    if (c === CT1) return RAW1;
    if (c === CT2) return RAW2;
    if (c === CT_ECB) return PT1;
    return {c[95:0], c[127:96]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  logic [127:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= dec_in;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign dec_out = dec_model(dpipe[LAT-1]);

  // Reference model state.
  logic [127:0] m_chain;
  logic [31:0]  exp_q[$];
  logic         last_q[$];
  logic [31:0]  got_q[$];
  int           n_checks, n_pass, n_fail, n_acc, n_words;
  logic         hold_vld, hold_last;
  logic [31:0]  hold_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, update model, return #1 after edge.
  task automatic cycle();
    logic [127:0] mask, pt;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      last_q.delete();
      m_chain  = '0;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("stall_valid", 128'(pt_valid), 128'(1));
        chk("stall_data", 128'(pt_data), 128'(hold_data));
        chk("stall_last", 128'(pt_last), 128'(hold_last));
      end
      if (pt_valid && pt_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 128'(pt_valid), 128'(0));
        end else begin
          chk("word", 128'(pt_data), 128'(exp_q.pop_front()));
          chk("last", 128'(pt_last), 128'(last_q.pop_front()));
          got_q.push_back(pt_data);
          n_words++;
        end
      end
      hold_vld  = pt_valid && !pt_ready;
      hold_data = pt_data;
      hold_last = pt_last;
      if (ct_valid && ct_ready) begin
        mask = cbc_en ? (iv_load ? iv_in : m_chain) : 128'd0;
        pt   = dec_model(ct_in) ^ mask;
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(pt[127-32*i -: 32]);
          last_q.push_back(i == 3);
        end
        n_acc++;
        if (cbc_en) m_chain = ct_in;
        else if (iv_load) m_chain = iv_in;
      end else if (iv_load) begin
        m_chain = iv_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    ct_valid = 1'b0;
    iv_load  = 1'b0;
    pt_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    repeat (LAT + 2) cycle();
    chk("idle_valid", 128'(pt_valid), 128'(0));
  endtask

  task automatic chk_block(input string tag, input int base, input logic [127:0] blk);
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > base + i) chk(tag, 128'(got_q[base+i]), 128'(blk_word(blk, 2'(i))));
      else chk({tag, "_missing"}, 128'(got_q.size()), 128'(base + i + 1));
    end
  endtask

  task automatic send(input logic [127:0] ct, input logic cbc, input logic ivl);
    ct_valid = 1'b1;
    ct_in    = ct;
    cbc_en   = cbc;
    iv_load  = ivl;
    cycle();
    ct_valid = 1'b0;
    iv_load  = 1'b0;
  endtask

  initial begin
    int acc0, words0;
    n_checks = 0; n_pass = 0; n_fail = 0; n_acc = 0; n_words = 0;
    m_chain = '0; hold_vld = 1'b0; hold_data = '0; hold_last = 1'b0;
    rst = 1'b1; iv_load = 1'b0; iv_in = '0; cbc_en = 1'b0;
    ct_valid = 1'b0; ct_in = '0; pt_ready = 1'b0;

    // Reset state.
    cycle();
    cycle();
    chk("rst_ct_ready", 128'(ct_ready), 128'(0));
    chk("rst_pt_valid", 128'(pt_valid), 128'(0));
    chk("rst_pt_data", 128'(pt_data), 128'(0));
    chk("rst_pt_last", 128'(pt_last), 128'(0));
    rst = 1'b0;
    #1;
    chk("ct_ready_after_rst", 128'(ct_ready), 128'(1));

    // CBC known-answer.
    got_q.delete();
    pt_ready = 1'b1;
    iv_in = IV; iv_load = 1'b1;
    cycle();
    iv_load = 1'b0;
    send(CT1, 1'b1, 1'b0);
    send(CT2, 1'b1, 1'b0);
    drain(60);
    chk_block("cbc_b1", 0, PT1);
    chk_block("cbc_b2", 4, PT2);

    // ECB leaves the chain alone: the following CBC block still uses IV.
    got_q.delete();
    iv_in = IV; iv_load = 1'b1;
    cycle();
    iv_load = 1'b0;
    send(CT_ECB, 1'b0, 1'b0);
    send(CT1, 1'b1, 1'b0);
    drain(60);
    chk_block("ecb_b", 0, PT1);
    chk_block("ecb_chain", 4, PT1);

    // iv_load in the same cycle as the first accept.
    got_q.delete();
    iv_in = 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe; iv_load = 1'b1;
    cycle();
    iv_in = IV;
    send(CT1, 1'b1, 1'b1);
    send(CT2, 1'b1, 1'b0);
    drain(60);
    chk_block("ivacc_b1", 0, PT1);
    chk_block("ivacc_b2", 4, PT2);

    // Backpressure: exactly DEPTH blocks accepted, then ct_ready drops.
    acc0 = n_acc;
    words0 = n_words;
    pt_ready = 1'b0;
    ct_valid = 1'b1;
    for (int i = 0; i < int'(DEPTH + LAT + 4); i++) begin
      ct_in  = {$urandom, $urandom, $urandom, $urandom};
      cbc_en = 1'($urandom);
      cycle();
    end
    chk("bp_accepted", 128'(n_acc - acc0), 128'(DEPTH));
    chk("bp_ct_ready", 128'(ct_ready), 128'(0));
    drain(200);
    chk("bp_words", 128'(n_words - words0), 128'(4 * DEPTH));

    // Randomised traffic with pseudo-random output stalls.
    for (int i = 0; i < 400; i++) begin
      ct_valid = 1'($urandom);
      ct_in    = {$urandom, $urandom, $urandom, $urandom};
      cbc_en   = ($urandom_range(0, 3) != 0);
      iv_load  = ($urandom_range(0, 7) == 0);
      iv_in    = {$urandom, $urandom, $urandom, $urandom};
      pt_ready = 1'($urandom);
      cycle();
    end
    drain(400);

    // Reset with two blocks in flight and word 1 of a buffered block pending.
    pt_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !pt_valid; i++) cycle();
    chk("rs_pending", 128'(pt_valid), 128'(1));
    pt_ready = 1'b1;
    cycle();
    pt_ready = 1'b0;
    iv_in = IV;
    send(CT1, 1'b1, 1'b1);
    send(CT2, 1'b1, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rs_pt_valid", 128'(pt_valid), 128'(0));
    pt_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("rs_quiet", 128'(pt_valid), 128'(0));
    end
    // Chain was cleared: a CBC block without iv_load gets a zero mask.
    got_q.delete();
    send(CT1, 1'b1, 1'b0);
    drain(60);
    chk_block("rs_chain0", 0, RAW1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
